uart_tx_model: RTL and testbench

UART_TX_MODEL -- requirements
Module: uart_tx_model

---
 rtl/uart_tx_model.sv | 205 ++++++++++++++++++++
 tb/tb_uart_tx_model.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_model.sv
// UART transmitter with a byte-wide transmit FIFO.
// Frames are start bit, PAYLOAD_BITS data bits sent LSB first, then
// STOP_BITS stop bits. Every line bit lasts CLK_HZ/BIT_RATE clocks.
// Frames run back-to-back while the FIFO holds data and uart_tx_en is high.
module uart_tx_model #(
  parameter int BIT_RATE     = 9600,
  parameter int CLK_HZ       = 50_000_000,
  parameter int PAYLOAD_BITS = 8,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        uart_tx_en,
  input  logic                        wr_valid,
  input  logic [7:0]                  wr_data,
  output logic                        wr_ready,
  output logic                        uart_txd,
  output logic                        uart_tx_busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overflow
);

  localparam int CYCLES_PER_BIT = CLK_HZ / BIT_RATE;
  localparam int STOP_CYCLES    = STOP_BITS * CYCLES_PER_BIT;
  localparam int AW             = $clog2(FIFO_DEPTH);
  localparam int CW             = AW + 1;
  // The baud counter must reach the longest single-state hold, which is STOP.
  localparam int BW             = $clog2(STOP_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  // FIFO storage and bookkeeping
  logic [7:0]              mem_q [FIFO_DEPTH];
  logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]           count_q, count_d;
  logic                    wr_ready_q, wr_ready_d;
  logic                    overflow_q, overflow_d;
  logic                    full_s, push_s, pop_s, can_start_s;
  logic [7:0]              head_s;

  // Transmit engine
  state_e                  state_q, state_d;
  logic [BW-1:0]           baud_q, baud_d;
  logic [2:0]              bit_q, bit_d;
  logic [PAYLOAD_BITS-1:0] shift_q, shift_d;
  logic                    txd_q, txd_d;
  logic                    busy_q, busy_d;

  assign full_s      = (count_q == CW'(FIFO_DEPTH));
  assign push_s      = wr_valid && !full_s;
  assign head_s      = mem_q[rd_ptr_q];
  assign can_start_s = uart_tx_en && (count_q != CW'(0));

  // FIFO storage: written on accepted pushes only, no reset needed on data.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  // FIFO pointers, occupancy and sticky overflow flag, next-state logic.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (wr_valid && full_s) begin
      overflow_d = 1'b1;
    end else begin
      overflow_d = overflow_q;
    end
    wr_ready_d = (count_d != CW'(FIFO_DEPTH));
  end

  // Frame sequencer: decides line level, bit position and FIFO pops.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    txd_d   = txd_q;
    pop_s   = 1'b0;
    case (state_q)
      IDLE: begin
        if (can_start_s) begin
          pop_s   = 1'b1;
          state_d = START;
          baud_d  = BW'(0);
          bit_d   = 3'd0;
          shift_d = head_s[PAYLOAD_BITS-1:0];
          txd_d   = 1'b0;
        end else begin
          txd_d   = 1'b1;
        end
      end
      START: begin
        if (baud_q == BW'(CYCLES_PER_BIT - 1)) begin
          state_d = DATA;
          baud_d  = BW'(0);
          txd_d   = shift_q[0];
        end else begin
          baud_d  = baud_q + BW'(1);
        end
      end
      DATA: begin
        if (baud_q == BW'(CYCLES_PER_BIT - 1)) begin
          baud_d = BW'(0);
          if (bit_q == 3'(PAYLOAD_BITS - 1)) begin
            state_d = STOP;
            txd_d   = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = shift_q >> 1;
            txd_d   = shift_q[1];
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      STOP: begin
        if (baud_q == BW'(STOP_CYCLES - 1)) begin
          // Last stop clock: behave like IDLE so queued frames follow with no gap.
          baud_d = BW'(0);
          bit_d  = 3'd0;
          if (can_start_s) begin
            pop_s   = 1'b1;
            state_d = START;
            shift_d = head_s[PAYLOAD_BITS-1:0];
            txd_d   = 1'b0;
          end else begin
            state_d = IDLE;
            txd_d   = 1'b1;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        baud_d  = BW'(0);
        bit_d   = 3'd0;
        txd_d   = 1'b1;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // All state and registered outputs; reset returns the line to idle-high.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q   <= AW'(0);
      rd_ptr_q   <= AW'(0);
      count_q    <= CW'(0);
      wr_ready_q <= 1'b1;
      overflow_q <= 1'b0;
      state_q    <= IDLE;
      baud_q     <= BW'(0);
      bit_q      <= 3'd0;
      shift_q    <= PAYLOAD_BITS'(0);
      txd_q      <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      wr_ready_q <= wr_ready_d;
      overflow_q <= overflow_d;
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      txd_q      <= txd_d;
      busy_q     <= busy_d;
    end
  end

  assign wr_ready     = wr_ready_q;
  assign uart_txd     = txd_q;
  assign uart_tx_busy = busy_q;
  assign fifo_count   = count_q;
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_uart_tx_model.sv
// Directed bench for uart_tx_model at 10 clocks per bit.
// dut: 8N1, 16-entry FIFO. dut2: 7 data bits, 2 stop bits.
module tb_uart_tx_model;

  logic       clk = 1'b0;
  logic       resetn;
  logic       uart_tx_en, wr_valid, wr_ready, uart_txd, uart_tx_busy, overflow;
  logic [7:0] wr_data;
  logic [4:0] fifo_count;
  logic       uart_tx_en2, wr_valid2, wr_ready2, uart_txd2, uart_tx_busy2, overflow2;
  logic [7:0] wr_data2;
  logic [4:0] fifo_count2;

  int checks = 0;
  int errors = 0;
  int waited, cnt0;
  logic bad;

  uart_tx_model #(
    .BIT_RATE(1_000_000), .CLK_HZ(10_000_000), .PAYLOAD_BITS(8),
    .STOP_BITS(1), .FIFO_DEPTH(16)
  ) dut (
    .clk(clk), .resetn(resetn), .uart_tx_en(uart_tx_en), .wr_valid(wr_valid),
    .wr_data(wr_data), .wr_ready(wr_ready), .uart_txd(uart_txd),
    .uart_tx_busy(uart_tx_busy), .fifo_count(fifo_count), .overflow(overflow)
  );

  uart_tx_model #(
    .BIT_RATE(1_000_000), .CLK_HZ(10_000_000), .PAYLOAD_BITS(7),
    .STOP_BITS(2), .FIFO_DEPTH(16)
  ) dut2 (
    .clk(clk), .resetn(resetn), .uart_tx_en(uart_tx_en2), .wr_valid(wr_valid2),
    .wr_data(wr_data2), .wr_ready(wr_ready2), .uart_txd(uart_txd2),
    .uart_tx_busy(uart_tx_busy2), .fifo_count(fifo_count2), .overflow(overflow2)
  );

  always #50 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic line_txd(input int sel);
    return (sel == 0) ? uart_txd : uart_txd2;
  endfunction

  function automatic logic line_busy(input int sel);
    return (sel == 0) ? uart_tx_busy : uart_tx_busy2;
  endfunction

  // One write; returns 1 time unit after the edge that accepts it.
  task automatic push(input int sel, input logic [7:0] b);
    @(posedge clk); #1;
    if (sel == 0) begin wr_valid = 1'b1; wr_data = b; end
    else begin wr_valid2 = 1'b1; wr_data2 = b; end
    @(posedge clk); #1;
    wr_valid  = 1'b0;
    wr_valid2 = 1'b0;
  endtask

  // Waits (bounded) for a start bit, then checks every clock of the frame, one check per bit.
  task automatic check_frame(input string tag, input int sel, input logic [7:0] b,
                             input int nbits, input int nstop, input int max_wait,
                             input int drop_at, output int w, output int c0);
    logic e;
    logic bb;
    w = 0;
    @(negedge clk);
    while (line_txd(sel) !== 1'b0 && w < max_wait) begin
      @(negedge clk);
      w++;
    end
    c0 = (sel == 0) ? int'(fifo_count) : int'(fifo_count2);
    for (int j = 0; j < 1 + nbits + nstop; j++) begin
      bb = 1'b0;
      if (j == 0) e = 1'b0;
      else if (j <= nbits) e = b[j-1];
      else e = 1'b1;
      for (int c = 0; c < 10; c++) begin
        if (j * 10 + c > 0) @(negedge clk);
        if (j * 10 + c == drop_at) uart_tx_en = 1'b0;
        if (line_txd(sel) !== e || line_busy(sel) !== 1'b1) bb = 1'b1;
      end
      chk($sformatf("%s_bit%0d", tag, j), 32'(bb), 32'd0);
    end
  endtask

  initial begin
    resetn = 1'b1; uart_tx_en = 1'b0; wr_valid = 1'b0; wr_data = 8'h00;
    uart_tx_en2 = 1'b1; wr_valid2 = 1'b0; wr_data2 = 8'h00;

    // Reset state
    #20 resetn = 1'b0;
    #1;
    chk("rst_txd", 32'(uart_txd), 32'd1);
    chk("rst_busy", 32'(uart_tx_busy), 32'd0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_ready", 32'(wr_ready), 32'd1);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_txd2", 32'(uart_txd2), 32'd1);
    chk("rst_ready2", 32'(wr_ready2), 32'd1);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    uart_tx_en = 1'b1;
    repeat (2) @(negedge clk);

    // Single 0xA5 frame, one-clock latency, 100 clocks busy
    push(0, 8'hA5);
    chk("a5_count", 32'(fifo_count), 32'd1);
    check_frame("a5", 0, 8'hA5, 8, 1, 5, -1, waited, cnt0);
    chk("a5_latency", 32'(waited), 32'd1);
    @(negedge clk);
    chk("a5_busy_end", 32'(uart_tx_busy), 32'd0);
    chk("a5_txd_end", 32'(uart_txd), 32'd1);

    // Two queued bytes -> contiguous frames, occupancy 1,2,1,0
    uart_tx_en = 1'b0;
    push(0, 8'h55);
    chk("b2b_count1", 32'(fifo_count), 32'd1);
    push(0, 8'h0F);
    chk("b2b_count2", 32'(fifo_count), 32'd2);
    uart_tx_en = 1'b1;
    check_frame("b2b_55", 0, 8'h55, 8, 1, 3, -1, waited, cnt0);
    chk("b2b_count3", 32'(cnt0), 32'd1);
    check_frame("b2b_0f", 0, 8'h0F, 8, 1, 0, -1, waited, cnt0);
    chk("b2b_gap", 32'(waited), 32'd0);
    chk("b2b_count4", 32'(cnt0), 32'd0);
    @(negedge clk);
    chk("b2b_idle", 32'(uart_tx_busy), 32'd0);

    // Fill while disabled, overflow on the 17th write, then drain in order
    uart_tx_en = 1'b0;
    for (int i = 0; i < 17; i++) begin
      @(posedge clk); #1;
      wr_valid = 1'b1;
      wr_data  = 8'(i * 37 + 3);
      if (i == 16) begin
        chk("full_ready", 32'(wr_ready), 32'd0);
        chk("full_count", 32'(fifo_count), 32'd16);
        chk("full_ovf_pre", 32'(overflow), 32'd0);
      end
    end
    @(posedge clk); #1;
    wr_valid = 1'b0;
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("ovf_count", 32'(fifo_count), 32'd16);
    chk("ovf_txd", 32'(uart_txd), 32'd1);
    chk("ovf_busy", 32'(uart_tx_busy), 32'd0);
    uart_tx_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check_frame($sformatf("drain%0d", i), 0, 8'(i * 37 + 3), 8, 1, (i == 0) ? 3 : 0, -1, waited, cnt0);
      if (i > 0) chk($sformatf("drain%0d_gap", i), 32'(waited), 32'd0);
    end
    @(negedge clk);
    chk("drain_empty", 32'(fifo_count), 32'd0);
    chk("drain_idle", 32'(uart_tx_busy), 32'd0);
    chk("ovf_sticky", 32'(overflow), 32'd1);

    // Enable drops at clock 40: frame completes, next byte stalls
    uart_tx_en = 1'b0;
    push(0, 8'h81);
    push(0, 8'h42);
    uart_tx_en = 1'b1;
    check_frame("endrop", 0, 8'h81, 8, 1, 3, 40, waited, cnt0);
    bad = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (uart_txd !== 1'b1 || uart_tx_busy !== 1'b0 || fifo_count !== 5'd1) bad = 1'b1;
    end
    chk("endrop_stall", 32'(bad), 32'd0);
    uart_tx_en = 1'b1;
    check_frame("resume_42", 0, 8'h42, 8, 1, 3, -1, waited, cnt0);
    chk("resume_wait", 32'(waited), 32'd0);

    // Reset at clock 55 of a frame
    push(0, 8'h99);
    push(0, 8'h11);
    repeat (54) @(negedge clk);
    chk("midrst_busy_pre", 32'(uart_tx_busy), 32'd1);
    chk("midrst_count_pre", 32'(fifo_count), 32'd1);
    resetn = 1'b0;
    #1;
    chk("midrst_txd", 32'(uart_txd), 32'd1);
    chk("midrst_busy", 32'(uart_tx_busy), 32'd0);
    chk("midrst_count", 32'(fifo_count), 32'd0);
    chk("midrst_ready", 32'(wr_ready), 32'd1);
    chk("midrst_ovf", 32'(overflow), 32'd0);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    bad = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (uart_txd !== 1'b1 || uart_tx_busy !== 1'b0 || fifo_count !== 5'd0) bad = 1'b1;
    end
    chk("postrst_idle", 32'(bad), 32'd0);
    push(0, 8'h3C);
    check_frame("postrst_3c", 0, 8'h3C, 8, 1, 5, -1, waited, cnt0);
    chk("postrst_latency", 32'(waited), 32'd1);
    @(negedge clk);
    chk("postrst_end", 32'(uart_tx_busy), 32'd0);

    // 7 data bits, 2 stop bits; bit 7 of the written byte is ignored
    push(1, 8'hFF);
    check_frame("p7_ff", 1, 8'h7F, 7, 2, 5, -1, waited, cnt0);
    chk("p7_latency", 32'(waited), 32'd1);
    @(negedge clk);
    chk("p7_busy_end", 32'(uart_tx_busy2), 32'd0);
    chk("p7_txd_end", 32'(uart_txd2), 32'd1);
    push(1, 8'hAA);
    check_frame("p7_aa", 1, 8'h2A, 7, 2, 5, -1, waited, cnt0);
    @(negedge clk);
    chk("p7_aa_end", 32'(uart_tx_busy2), 32'd0);
    chk("p7_ovf", 32'(overflow2), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
